// File: rtl/bin_binary_search.sv
// Binary search of the sorted BIN table ROM for a KEY_W-bit key.
// found_index, binary_search_done and binary_search_found hold until the next accepted start or reset.
module bin_binary_search #(
   parameter int    DEPTH     = 2638,
   parameter int    IDX_W     = 12,
   parameter int    KEY_W     = 20,
   parameter string INIT_FILE = "./bindb/bin_numbers.mif"
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic             start,
   input  logic [KEY_W-1:0] bin_key,
   output logic             busy,
   output logic [IDX_W-1:0] found_index,
   output logic             binary_search_done,
   output logic             binary_search_found
);

   typedef enum logic [2:0] {IDLE, ADDR, READ, CMP, DONE} state_t;
   typedef logic [KEY_W-1:0] rom_t [DEPTH];

   // Ascending table contents: rom[i] = 100000 + 300*i.
   function automatic rom_t load_rom();
      rom_t r;
      for (int i = 0; i < DEPTH; i++) r[i] = KEY_W'(100000 + 300 * i);
      return r;
   endfunction

   rom_t rom = load_rom();

   state_t           state, state_nxt;
   logic [KEY_W-1:0] key, key_nxt;
   logic [IDX_W-1:0] lo, lo_nxt;
   logic [IDX_W-1:0] hi, hi_nxt;
   logic [IDX_W-1:0] mid, mid_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             busy_nxt, done_nxt, found_nxt;
   logic [IDX_W:0]   sum;
   logic [KEY_W-1:0] q;
   logic             post, hit;

   // NOTE: memory output registers carry no reset; they only need a valid address one cycle earlier.
   always_ff @(posedge CLOCK_50) begin
      q <= rom[mid];
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_nxt = state;
      key_nxt   = key;
      lo_nxt    = lo;
      hi_nxt    = hi;
      mid_nxt   = mid;
      idx_nxt   = found_index;
      busy_nxt  = busy;
      done_nxt  = binary_search_done;
      found_nxt = binary_search_found;
      post      = 1'b0;
      hit       = 1'b0;
      sum       = {1'b0, lo} + {1'b0, hi};

      case (state)
         IDLE, DONE: begin
            if (start) begin
               key_nxt   = bin_key;
               lo_nxt    = '0;
               hi_nxt    = IDX_W'(DEPTH - 1);
               idx_nxt   = '0;
               done_nxt  = 1'b0;
               found_nxt = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            mid_nxt   = sum[IDX_W:1];
            state_nxt = READ;
         end
         READ: state_nxt = CMP;
         CMP: begin
            // mid==lo / mid==hi guards end the search before lo/hi could wrap.
            if (key == q) begin
               post = 1'b1;
               hit  = 1'b1;
            end else if (key < q) begin
               if (mid == lo) post = 1'b1;
               else begin
                  hi_nxt    = mid - IDX_W'(1);
                  state_nxt = ADDR;
               end
            end else begin
               if (mid == hi) post = 1'b1;
               else begin
                  lo_nxt    = mid + IDX_W'(1);
                  state_nxt = ADDR;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (post) begin
         done_nxt  = 1'b1;
         busy_nxt  = 1'b0;
         found_nxt = hit;
         idx_nxt   = hit ? mid : '0;
         state_nxt = DONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state               <= IDLE;
         key                 <= '0;
         lo                  <= '0;
         hi                  <= '0;
         mid                 <= '0;
         found_index         <= '0;
         busy                <= 1'b0;
         binary_search_done  <= 1'b0;
         binary_search_found <= 1'b0;
      end else begin
         state               <= state_nxt;
         key                 <= key_nxt;
         lo                  <= lo_nxt;
         hi                  <= hi_nxt;
         mid                 <= mid_nxt;
         found_index         <= idx_nxt;
         busy                <= busy_nxt;
         binary_search_done  <= done_nxt;
         binary_search_found <= found_nxt;
      end
   end

endmodule

// File: doc/bin_binary_search.md
# bin_binary_search

Searches the sorted BIN table ROM for a 20-bit BIN key and reports the matching table index. Produces `found_index`, `binary_search_done` and `binary_search_found`, which the card-level and bank-name lookup blocks consume. Those consumers read `found_index` continuously and delay the done/found flags to match their own ROM latency. This block therefore holds all three results stable until the next search starts or reset occurs.

## Interface

- `DEPTH`, default 2638: number of BIN entries. Entries are sorted ascending, unsigned, with no duplicates.
- `IDX_W`, default 12: index width.
- `KEY_W`, default 20: BIN key width, unsigned binary (0 to 999999).
- `INIT_FILE`, default "./bindb/bin_numbers.mif": ROM init file, KEY_W bits wide, DEPTH words deep.
- `CLOCK_50`, in, 1: system clock. All state changes on the rising edge.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle request. Accepted only in IDLE or DONE.
- `bin_key`, in, KEY_W: key to search for. Sampled only on an accepted `start`.
- `busy`, out, 1: high from the accepted start until the result is posted.
- `found_index`, out, IDX_W: index of the match. Forced to 0 when not found.
- `binary_search_done`, out, 1: level signal. High from result posting until the next accepted start or reset.
- `binary_search_found`, out, 1: valid while done is high. 1 means an exact match was found.

## Operation

- Internal ROM is synchronous read with 1-cycle registered output, inferred from a reg array with `INIT_FILE`.
- Registers: `key` (KEY_W), `lo` (IDX_W), `hi` (IDX_W), `mid` (IDX_W).
- `mid` is computed as `(lo + hi) >> 1` using an IDX_W+1-bit sum, so there is no overflow.
- State machine states: IDLE, ADDR, READ, CMP, DONE.
- IDLE, or DONE, with `start`:
  - Latch `key`, set `lo`=0 and `hi`=DEPTH-1.
  - Clear done, found and `found_index`; set `busy`=1.
  - Go to ADDR.
- ADDR: register `mid`; go to READ.
- READ: ROM address = `mid`; ROM data is registered at the end of this cycle; go to CMP.
- CMP compares `key` against the ROM data `q`, unsigned:
  - `key` == `q`: post found=1 and `found_index`=`mid`.
  - `key` < `q`: if `mid` == `lo`, post not-found; otherwise `hi`=`mid`-1 and go to ADDR.
  - `key` > `q`: if `mid` == `hi`, post not-found; otherwise `lo`=`mid`+1 and go to ADDR.
- The `mid`==`lo` and `mid`==`hi` guards prevent index underflow and overflow. No signed arithmetic is needed.
- Posting a result means: done=1, `busy`=0, go to DONE. For not-found, `found_index`=0 and found=0.
- DONE: hold all outputs. A new `start` restarts the search exactly as from IDLE.
- `start` in ADDR, READ or CMP is ignored, and `bin_key` changes are ignored.
- Reset, including mid-search:
  - State goes to IDLE.
  - `busy`, `binary_search_done`, `binary_search_found` and `found_index` all go to 0.
  - `lo`, `hi`, `mid` and `key` go to 0.

## Timing

- Each probe takes 3 cycles (ADDR, READ, CMP).
- Let `start` be sampled at edge T0 and let k be the number of probes. Outputs update at edge T0+3k.
- The maximum k for DEPTH=2638 is 12, so worst-case latency is 36 cycles.
- `busy` rises at T0+1 and falls in the same edge that done rises.
- Restart from DONE: done and found fall at T0+1.
  - Downstream consumers see at least one low cycle of done between searches.
  - `found_index` reads 0 while busy.
- `found_index` and found are stable for the whole time done is high.

## Test plan

- Reset, then idle: all outputs 0. Release reset and wait 10 cycles with no start: outputs stay 0 and state is IDLE.
- First-probe hit, key = rom[1318]:
  - Response: done=1, found=1, `found_index`=1318 at T0+3.
  - `busy` is high for cycles T0+1 through T0+3.
  - Outputs hold for 20 cycles.
- Below range, key < rom[0], e.g. 0:
  - Probe sequence: 1318, 658, 328, 163, 81, 40, 19, 9, 4, 1, 0.
  - Response: done=1, found=0, index=0 at T0+33.
- Above range, key = 999999 > rom[2637]:
  - 12 probes, ending at 2637.
  - Response: done=1, found=0 at T0+36.
  - Also run key = rom[2637]: found=1, index=2637 at T0+36. Key = rom[0]: found=1, index=0 at T0+33.
- Gap miss, rom[500] < key < rom[501]: found=0, index=0.
  - Cross-check: every key rom[i] for i = 0..2637 returns index i with done within 36 cycles.
- Restart and reset:
  - `start` pulsed during READ: ignored, original result unchanged.
  - `start` in DONE with a new key: done falls at T0+1 and the new result posts.
  - `resetn` asserted at cycle 10 of a search: outputs 0 immediately.
  - A search after release completes correctly.
